// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM encoding, clog2 helper and default
// watchdog limit.
package sdram_arb_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    localparam int unsigned DefaultTimeout = 255;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or above ptr_i, wrapping modulo N.
module rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [IdxW-1:0] idx_o
);

    logic            found;
    logic [IdxW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = IdxW'((32'(ptr_i) + i) % N);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style SDRAM controller port among NUM_MASTERS tiles.
// Define SDRAM_ARB_TIMEOUT_EN to build in the stalled-slave watchdog (m_err pulse + release).
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT     = DefaultTimeout,
    localparam int unsigned SEL_W      = DATA_W / 8,
    localparam int unsigned IdxW       = clog2(NUM_MASTERS)
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic [NUM_MASTERS-1:0]        m_cyc,
    input  logic [NUM_MASTERS-1:0]        m_stb,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic [DATA_W-1:0]             m_dat_o,

    output logic                          s_cyc,
    output logic                          s_stb,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_adr,
    output logic [DATA_W-1:0]             s_dat_o,
    output logic [SEL_W-1:0]              s_sel,
    input  logic                          s_ack,
    input  logic [DATA_W-1:0]             s_dat_i,

    output logic [IdxW-1:0]               grant_id,
    output logic                          busy
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || TIMEOUT < 1) begin : g_bad_param
        $error("sdram_port_arbiter: NUM_MASTERS must be 2..16 and TIMEOUT nonzero");
    end

    arb_state_e             state_q, state_d;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [NUM_MASTERS-1:0] owner_oh_q, owner_oh_d;
    logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]        next_ptr;
    logic [NUM_MASTERS-1:0] pick_grant;
    logic [IdxW-1:0]        pick_idx;
    logic                   active;
    logic                   timeout_hit;

    rr_pick #(
        .N    (NUM_MASTERS),
        .IdxW (IdxW)
    ) u_rr_pick (
        .req_i   (m_cyc),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // Reset gates everything combinationally so a mid-burst reset cannot leak a beat or ack.
    assign active   = (state_q == StGrant) && !reset;
    assign next_ptr = (owner_q == IdxW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int unsigned WdRaw = clog2(TIMEOUT + 1);
    localparam int unsigned WdW   = (WdRaw < 8) ? 8 : ((WdRaw > 16) ? 16 : WdRaw);

    logic [WdW-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (!active || s_ack) begin
            wd_d = '0;
        end else if (s_stb) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout_hit = active && (wd_q == WdW'(TIMEOUT));
    assign m_err       = timeout_hit ? owner_oh_q : '0;
`else
    assign timeout_hit = 1'b0;
    assign m_err       = '0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        rr_ptr_d   = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (|m_cyc) begin
                    state_d    = StGrant;
                    owner_d    = pick_idx;
                    owner_oh_d = pick_grant;
                end
            end
            StGrant: begin
                if (!m_cyc[owner_q] || timeout_hit) begin
                    state_d  = StIdle;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            owner_oh_q <= NUM_MASTERS'(1);
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_comb begin
        s_cyc   = active;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_o = '0;
        s_sel   = '0;
        if (active) begin
            s_stb   = m_stb[owner_q];
            s_we    = m_we[owner_q];
            s_adr   = m_adr[32'(owner_q) * ADDR_W +: ADDR_W];
            s_dat_o = m_dat_i[32'(owner_q) * DATA_W +: DATA_W];
            s_sel   = m_sel[32'(owner_q) * SEL_W +: SEL_W];
        end
    end

    assign m_ack    = (active && s_ack) ? owner_oh_q : '0;
    assign m_dat_o  = s_dat_i;
    assign grant_id = owner_q;
    assign busy     = active;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (4 masters, TIMEOUT=16); follows SDRAM_ARB_TIMEOUT_EN.
module tb_sdram_port_arbiter;

    localparam int NM = 4;
    localparam int AW = 25;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int IW = 2;

    logic             clk;
    logic             reset;
    logic [NM-1:0]    m_cyc, m_stb, m_we, m_ack, m_err;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat_i;
    logic [NM*SW-1:0] m_sel;
    logic [DW-1:0]    m_dat_o;
    logic             s_cyc, s_stb, s_we, s_ack;
    logic [AW-1:0]    s_adr;
    logic [DW-1:0]    s_dat_o, s_dat_i;
    logic [SW-1:0]    s_sel;
    logic [IW-1:0]    grant_id;
    logic             busy;

    int checks = 0;
    int errors = 0;

    sdram_port_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT     (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_cyc    (m_cyc),
        .m_stb    (m_stb),
        .m_we     (m_we),
        .m_adr    (m_adr),
        .m_dat_i  (m_dat_i),
        .m_sel    (m_sel),
        .m_ack    (m_ack),
        .m_err    (m_err),
        .m_dat_o  (m_dat_o),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_adr    (s_adr),
        .s_dat_o  (s_dat_o),
        .s_sel    (s_sel),
        .s_ack    (s_ack),
        .s_dat_i  (s_dat_i),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "bench timeout");
    end

    function automatic logic [AW-1:0] adr_of(input int k);
        return AW'(32'h0ABC00 + k);
    endfunction

    function automatic logic [DW-1:0] dat_of(input int k);
        return 32'hD000_0000 + DW'(k * 17);
    endfunction

    function automatic logic [SW-1:0] sel_of(input int k);
        return SW'(k + 1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    logic [NM-1:0] oh;

    initial begin
        reset   = 1'b1;
        m_cyc   = 4'b1111;
        m_stb   = 4'b1111;
        m_we    = 4'b1010;
        s_ack   = 1'b1;
        s_dat_i = '0;
        for (int i = 0; i < NM; i++) begin
            m_adr[i*AW +: AW]   = adr_of(i);
            m_dat_i[i*DW +: DW] = dat_of(i);
            m_sel[i*SW +: SW]   = sel_of(i);
        end
        next();
        next();
        sample();
        check("rst_s_cyc", s_cyc, 0);
        check("rst_s_stb", s_stb, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_m_ack", m_ack, 0);
        check("rst_m_err", m_err, 0);

        // Single request from master 2: cycle 0 request, cycle 1 grant, cycle 3 ack.
        next();
        reset = 1'b0;
        s_ack = 1'b0;
        m_cyc = 4'b0100;
        m_stb = 4'b0100;
        sample();
        check("single_c0_s_cyc", s_cyc, 0);
        check("single_c0_s_adr", s_adr, 0);
        next();
        sample();
        check("single_c1_s_cyc", s_cyc, 1);
        check("single_c1_grant", grant_id, 2);
        check("single_c1_busy", busy, 1);
        check("single_c1_s_stb", s_stb, 1);
        check("single_c1_s_we", s_we, 0);
        check("single_c1_s_adr", s_adr, adr_of(2));
        check("single_c1_s_dat", s_dat_o, dat_of(2));
        check("single_c1_s_sel", s_sel, sel_of(2));
        next();
        next();
        s_ack   = 1'b1;
        s_dat_i = 32'hCAFE_F00D;
        sample();
        check("single_c3_m_ack", m_ack, 4'b0100);
        check("single_c3_m_dat_o", m_dat_o, 32'hCAFE_F00D);
        next();
        s_ack = 1'b0;
        m_cyc = 4'b0000;
        m_stb = 4'b0000;
        sample();
        check("single_c4_busy_hold", busy, 1);
        check("single_c4_m_ack", m_ack, 0);
        next();
        sample();
        check("single_c5_busy", busy, 0);
        check("single_c5_s_cyc", s_cyc, 0);
        check("single_c5_s_adr", s_adr, 0);
        check("single_c5_s_dat", s_dat_o, 0);

        // Wrap-around: pointer is 3 after master 2 released.
        m_cyc = 4'b0011;
        next();
        sample();
        check("wrap_first_grant", grant_id, 0);
        check("wrap_first_busy", busy, 1);
        next();
        m_cyc = 4'b0010;
        sample();
        check("wrap_release_busy", busy, 1);
        next();
        m_cyc = 4'b0011;
        sample();
        check("wrap_dead_cycle", busy, 0);
        next();
        sample();
        check("wrap_ptr_advanced", grant_id, 1);
        next();
        m_cyc = 4'b0000;
        next();

        // Reset in beat 2 of a master-3 burst.
        m_cyc = 4'b1000;
        m_stb = 4'b1000;
        next();
        s_ack = 1'b1;
        sample();
        check("rstmid_grant", grant_id, 3);
        check("rstmid_beat1_ack", m_ack, 4'b1000);
        check("rstmid_s_we", s_we, 1);
        next();
        reset = 1'b1;
        sample();
        check("rstmid_in_s_cyc", s_cyc, 0);
        check("rstmid_in_s_stb", s_stb, 0);
        check("rstmid_in_m_ack", m_ack, 0);
        check("rstmid_in_m_err", m_err, 0);
        next();
        reset = 1'b0;
        m_cyc = 4'b1111;
        m_stb = 4'b1111;
        sample();
        check("rstmid_after_s_cyc", s_cyc, 0);
        check("rstmid_after_busy", busy, 0);
        check("rstmid_after_m_ack", m_ack, 0);

        // Round robin with all four requesting; pointer must restart at 0.
        for (int k = 0; k < 5; k++) begin
            next();
            oh    = 4'b0001 << (k % 4);
            m_cyc = 4'b1111 & ~oh;
            sample();
            check("rr_grant", grant_id, 64'(k % 4));
            check("rr_busy", busy, 1);
            check("rr_m_ack", m_ack, oh);
            next();
            m_cyc = 4'b1111;
            sample();
            check("rr_dead_busy", busy, 0);
            check("rr_dead_m_ack", m_ack, 0);
        end

        // Burst hold: master 1 holds for 8 beats while master 3 waits.
        s_ack = 1'b0;
        m_cyc = 4'b1010;
        m_stb = 4'b1010;
        for (int b = 0; b < 8; b++) begin
            next();
            s_ack = 1'b1;
            sample();
            check("burst_grant", grant_id, 1);
            check("burst_m_ack", m_ack, 4'b0010);
            check("burst_s_adr", s_adr, adr_of(1));
        end
        next();
        s_ack = 1'b0;
        m_cyc = 4'b1000;
        sample();
        check("burst_fall_hold", grant_id, 1);
        check("burst_fall_busy", busy, 1);
        next();
        sample();
        check("burst_dead_busy", busy, 0);
        next();
        sample();
        check("burst_next_grant", grant_id, 3);
        check("burst_next_busy", busy, 1);
        next();
        m_cyc = 4'b0000;
        m_stb = 4'b0000;
        next();

        // Watchdog: master 2 stalls with s_ack low.
        m_cyc = 4'b0100;
        m_stb = 4'b0100;
        next();
        sample();
        check("wd_s_stb_rise", s_stb, 1);
        check("wd_m_err_c0", m_err, 0);
        for (int i = 1; i < 16; i++) begin
            next();
            sample();
            check("wd_stall_m_err", m_err, 0);
            check("wd_stall_busy", busy, 1);
        end
        next();
        sample();
`ifdef SDRAM_ARB_TIMEOUT_EN
        check("wd_err_pulse", m_err, 4'b0100);
        check("wd_err_busy", busy, 1);
        next();
        sample();
        check("wd_err_single", m_err, 0);
        check("wd_idle_after", busy, 0);
`else
        check("wd_off_m_err", m_err, 0);
        check("wd_off_busy", busy, 1);
        next();
        sample();
        check("wd_off_m_err_later", m_err, 0);
        check("wd_off_busy_later", busy, 1);
`endif
        next();
        m_cyc = 4'b0000;
        m_stb = 4'b0000;
        next();
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
